accel_tilt_filter: RTL and testbench

ACCEL_TILT_FILTER -- requirements
Module: accel_tilt_filter

---
 rtl/accel_tilt_filter.sv | 133 +++++++++++++
 tb/tb_accel_tilt_filter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_tilt_filter.sv
// Accelerometer tilt filter: ticked sampling, stability check, 8-sample moving average, tilt flags.
// Optional macro ACCEL_HYST_EN adds set/clear hysteresis to the tilt flags.
module accel_tilt_filter #(
  parameter int                 SAMPLE_DIV = 100000,
  parameter logic signed [15:0] THRESH     = 16'sd250,
  parameter logic signed [15:0] HYST       = 16'sd32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] y_value,
  input  logic signed [15:0] z_value,
  output logic signed [15:0] y_avg,
  output logic signed [15:0] z_avg,
  output logic               avg_valid,
  output logic               avg_strobe,
  output logic               tilt_left,
  output logic               tilt_right,
  output logic               face_down,
  output logic [7:0]         drop_count
);

  localparam int DW = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {IDLE, CHECK, ACCUM, PUBLISH} state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      div_q;
  logic               tick;
  logic signed [15:0] cap_y_q, cap_z_q;
  logic signed [15:0] ybuf_q [8];
  logic signed [15:0] zbuf_q [8];
  logic signed [18:0] sum_y_q, sum_z_q;
  logic [2:0]         ptr_q;
  logic [3:0]         cnt_q;
  logic               cap_en, drop_en, accum_en, pub_en;
  logic signed [15:0] y_new, z_new;
  logic               valid_nx, right_nx, left_nx, down_nx;

  assign tick = (div_q == DW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = CHECK;
      CHECK:   state_d = (y_value == cap_y_q && z_value == cap_z_q) ? ACCUM : IDLE;
      ACCUM:   state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_en   = (state_q == IDLE) && tick;
    drop_en  = (state_q == CHECK) && !(y_value == cap_y_q && z_value == cap_z_q);
    accum_en = (state_q == ACCUM);
    pub_en   = (state_q == PUBLISH);
  end

  // Arithmetic >>>3 truncated to 16 bits is exactly bits [18:3] of the sum.
  always_comb begin
    y_new    = sum_y_q[18:3];
    z_new    = sum_z_q[18:3];
    valid_nx = (cnt_q == 4'd8);
`ifdef ACCEL_HYST_EN
    right_nx = tilt_right ? !(y_new < (THRESH - HYST))    : (y_new > THRESH);
    left_nx  = tilt_left  ? !(y_new > -(THRESH - HYST))   : (y_new < -THRESH);
    down_nx  = face_down  ? !(z_new > -(THRESH - HYST))   : (z_new < -THRESH);
`else
    right_nx = (y_new > THRESH);
    left_nx  = (y_new < -THRESH);
    down_nx  = (z_new < -THRESH);
`endif
    if (!valid_nx) begin
      right_nx = 1'b0;
      left_nx  = 1'b0;
      down_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      cap_y_q    <= '0;
      cap_z_q    <= '0;
      sum_y_q    <= '0;
      sum_z_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        ybuf_q[i] <= '0;
        zbuf_q[i] <= '0;
      end
      y_avg      <= '0;
      z_avg      <= '0;
      avg_valid  <= 1'b0;
      avg_strobe <= 1'b0;
      tilt_left  <= 1'b0;
      tilt_right <= 1'b0;
      face_down  <= 1'b0;
      drop_count <= '0;
    end else begin
      div_q      <= tick ? '0 : div_q + DW'(1);
      avg_strobe <= pub_en;
      if (cap_en) begin
        cap_y_q <= y_value;
        cap_z_q <= z_value;
      end
      if (drop_en && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (accum_en) begin
        sum_y_q <= sum_y_q + {{3{cap_y_q[15]}}, cap_y_q} - {{3{ybuf_q[ptr_q][15]}}, ybuf_q[ptr_q]};
        sum_z_q <= sum_z_q + {{3{cap_z_q[15]}}, cap_z_q} - {{3{zbuf_q[ptr_q][15]}}, zbuf_q[ptr_q]};
        ybuf_q[ptr_q] <= cap_y_q;
        zbuf_q[ptr_q] <= cap_z_q;
        ptr_q <= ptr_q + 3'd1;
        if (cnt_q != 4'd8) cnt_q <= cnt_q + 4'd1;
      end
      if (pub_en) begin
        y_avg      <= y_new;
        z_avg      <= z_new;
        avg_valid  <= valid_nx;
        tilt_right <= right_nx;
        tilt_left  <= left_nx;
        face_down  <= down_nx;
      end
    end
  end

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Directed bench for accel_tilt_filter with SAMPLE_DIV=8, THRESH=250, HYST=32.
module tb_accel_tilt_filter;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] y_value = '0;
  logic signed [15:0] z_value = '0;
  logic signed [15:0] y_avg, z_avg;
  logic               avg_valid, avg_strobe, tilt_left, tilt_right, face_down;
  logic [7:0]         drop_count;

  int checks = 0;
  int failures = 0;

  accel_tilt_filter #(
    .SAMPLE_DIV(8),
    .THRESH(16'sd250),
    .HYST(16'sd32)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .y_value(y_value),
    .z_value(z_value),
    .y_avg(y_avg),
    .z_avg(z_avg),
    .avg_valid(avg_valid),
    .avg_strobe(avg_strobe),
    .tilt_left(tilt_left),
    .tilt_right(tilt_right),
    .face_down(face_down),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reset, releasing on a negedge so cycle counting from release is exact.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns negedges elapsed until avg_strobe is seen high (bounded).
  task automatic wait_strobe(output int cycles, output bit got);
    cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (avg_strobe) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({y_avg, z_avg, avg_valid, avg_strobe, tilt_left, tilt_right, face_down, drop_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got y=%0d z=%0d v=%b s=%b l=%b r=%b d=%b drop=%0d want all 0",
               y_avg, z_avg, avg_valid, avg_strobe, tilt_left, tilt_right, face_down, drop_count);
    end
  endtask

  task automatic test_tilt_right();
    int c; bit g;
    y_value = 16'sd400; z_value = 16'sd0;
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      wait_strobe(c, g);
      checks++;
      if (!g) begin failures++; $display("FAIL tr_strobe_timeout publish %0d", n); end
      if (n == 1) begin
        checks++;
        if (c != 11) begin failures++; $display("FAIL tr_first_latency got %0d want 11", c); end
      end
      if (n == 7) begin
        checks++;
        if (y_avg !== 16'sd350 || avg_valid !== 1'b0 || tilt_right !== 1'b0) begin
          failures++;
          $display("FAIL tr_pub7 got y=%0d v=%b r=%b want 350 0 0", y_avg, avg_valid, tilt_right);
        end
      end
    end
    checks++;
    if (y_avg !== 16'sd400 || z_avg !== 16'sd0 || avg_valid !== 1'b1 || tilt_right !== 1'b1 ||
        tilt_left !== 1'b0 || face_down !== 1'b0) begin
      failures++;
      $display("FAIL tr_pub8 got y=%0d z=%0d v=%b r=%b l=%b d=%b want 400 0 1 1 0 0",
               y_avg, z_avg, avg_valid, tilt_right, tilt_left, face_down);
    end
    @(negedge clk);
    checks++;
    if (avg_strobe !== 1'b0) begin failures++; $display("FAIL tr_strobe_width got %b want 0", avg_strobe); end
  endtask

  task automatic test_negative();
    int c; bit g;
    y_value = -16'sd8; z_value = -16'sd1000;
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      wait_strobe(c, g);
      checks++;
      if (!g) begin failures++; $display("FAIL neg_strobe_timeout publish %0d", n); end
      if (n == 1) begin
        checks++;
        if (y_avg !== -16'sd1 || z_avg !== -16'sd125 || face_down !== 1'b0) begin
          failures++;
          $display("FAIL neg_pub1 got y=%0d z=%0d d=%b want -1 -125 0", y_avg, z_avg, face_down);
        end
      end
    end
    checks++;
    if (y_avg !== -16'sd8 || z_avg !== -16'sd1000 || avg_valid !== 1'b1 || tilt_left !== 1'b0 ||
        tilt_right !== 1'b0 || face_down !== 1'b1) begin
      failures++;
      $display("FAIL neg_pub8 got y=%0d z=%0d v=%b l=%b r=%b d=%b want -8 -1000 1 0 0 1",
               y_avg, z_avg, avg_valid, tilt_left, tilt_right, face_down);
    end
    y_value = -16'sd400;
    for (int n = 1; n <= 8; n++) wait_strobe(c, g);
    checks++;
    if (y_avg !== -16'sd400 || tilt_left !== 1'b1 || tilt_right !== 1'b0 || face_down !== 1'b1) begin
      failures++;
      $display("FAIL neg_left got y=%0d l=%b r=%b d=%b want -400 1 0 1", y_avg, tilt_left, tilt_right, face_down);
    end
  endtask

  task automatic test_hysteresis();
    int c; bit g;
    bit exp_hold;
`ifdef ACCEL_HYST_EN
    exp_hold = 1'b1;
`else
    exp_hold = 1'b0;
`endif
    y_value = 16'sd300; z_value = 16'sd0;
    do_reset();
    for (int n = 1; n <= 8; n++) wait_strobe(c, g);
    checks++;
    if (y_avg !== 16'sd300 || tilt_right !== 1'b1) begin
      failures++; $display("FAIL hy_300 got y=%0d r=%b want 300 1", y_avg, tilt_right);
    end
    y_value = 16'sd230;
    wait_strobe(c, g);
    checks++;
    if (y_avg !== 16'sd291 || tilt_right !== 1'b1) begin
      failures++; $display("FAIL hy_291 got y=%0d r=%b want 291 1", y_avg, tilt_right);
    end
    for (int n = 2; n <= 8; n++) wait_strobe(c, g);
    checks++;
    if (y_avg !== 16'sd230 || tilt_right !== exp_hold) begin
      failures++; $display("FAIL hy_230 got y=%0d r=%b want 230 %b", y_avg, tilt_right, exp_hold);
    end
    y_value = 16'sd200;
    for (int n = 1; n <= 8; n++) wait_strobe(c, g);
    checks++;
    if (y_avg !== 16'sd200 || tilt_right !== 1'b0) begin
      failures++; $display("FAIL hy_200 got y=%0d r=%b want 200 0", y_avg, tilt_right);
    end
  endtask

  task automatic test_drop();
    bit seen = 1'b0;
    y_value = 16'sd0; z_value = 16'sd0;
    do_reset();
    for (int cyc = 1; cyc <= 2100; cyc++) begin
      @(negedge clk);
      y_value = (y_value == 16'sd0) ? 16'sd1 : 16'sd0;
      if (avg_strobe) seen = 1'b1;
      if (cyc == 30) begin
        checks++;
        if (drop_count !== 8'd3) begin failures++; $display("FAIL drop_early got %0d want 3", drop_count); end
      end
    end
    checks++;
    if (drop_count !== 8'd255) begin failures++; $display("FAIL drop_sat got %0d want 255", drop_count); end
    checks++;
    if (seen) begin failures++; $display("FAIL drop_no_strobe got strobe=1 want none"); end
  endtask

  task automatic test_reset_mid();
    int c; bit g;
    bit seen = 1'b0;
    y_value = 16'sd100; z_value = -16'sd100;
    do_reset();
    wait_strobe(c, g);
    wait_strobe(c, g);
    checks++;
    if (!g || y_avg !== 16'sd25 || z_avg !== -16'sd25) begin
      failures++; $display("FAIL rm_pre got g=%b y=%0d z=%0d want 1 25 -25", g, y_avg, z_avg);
    end
    // Second strobe seen after posedge 19; six more negedges lands in the ACCUM cycle of the third sample.
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({y_avg, z_avg, avg_valid, avg_strobe, tilt_left, tilt_right, face_down, drop_count} !== '0) begin
      failures++; $display("FAIL rm_clear got y=%0d z=%0d s=%b want all 0", y_avg, z_avg, avg_strobe);
    end
    repeat (3) begin
      @(negedge clk);
      if (avg_strobe) seen = 1'b1;
    end
    rst_n = 1'b1;
    checks++;
    if (seen) begin failures++; $display("FAIL rm_strobe_in_reset got 1 want 0"); end
    wait_strobe(c, g);
    checks++;
    if (!g || c != 11) begin failures++; $display("FAIL rm_first_tick got g=%b lat=%0d want 1 11", g, c); end
    checks++;
    if (y_avg !== 16'sd12 || z_avg !== -16'sd13) begin
      failures++; $display("FAIL rm_restart got y=%0d z=%0d want 12 -13", y_avg, z_avg);
    end
  endtask

  task automatic test_window();
    int c; bit g;
    y_value = 16'sd0; z_value = 16'sd0;
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      if (n == 9) y_value = 16'sd800;
      wait_strobe(c, g);
      checks++;
      if (!g || c != ((n == 1) ? 11 : 8)) begin
        failures++; $display("FAIL win_spacing publish %0d got g=%b c=%0d", n, g, c);
      end
    end
    checks++;
    if (y_avg !== 16'sd200 || avg_valid !== 1'b1 || tilt_right !== 1'b0) begin
      failures++; $display("FAIL win_final got y=%0d v=%b r=%b want 200 1 0", y_avg, avg_valid, tilt_right);
    end
    y_value = 16'sd800;
    for (int n = 1; n <= 6; n++) wait_strobe(c, g);
    checks++;
    if (y_avg !== 16'sd800 || tilt_right !== 1'b1) begin
      failures++; $display("FAIL win_full got y=%0d r=%b want 800 1", y_avg, tilt_right);
    end
  endtask

  initial begin
    test_reset();
    test_tilt_right();
    test_negative();
    test_hysteresis();
    test_drop();
    test_reset_mid();
    test_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
